// File: rtl/acc_drain_pkg.sv
// -----------------------------------------------------------------------------
// acc_drain_pkg
// Shared definitions for the accelerator result drain:
//   - default beat / word widths and the derived words-per-beat ratio
//   - one-hot FSM state type
//   - saturating increment helper for the optional beat counter
// -----------------------------------------------------------------------------
package acc_drain_pkg;

  localparam int DEF_DATA_W = 128;
  localparam int DEF_OUT_W  = 32;
  localparam int DEF_RATIO  = DEF_DATA_W / DEF_OUT_W;
  localparam int DEF_IDX_W  = (DEF_RATIO > 1) ? $clog2(DEF_RATIO) : 1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'b0001,
    ST_WAIT_DATA = 4'b0010,
    ST_SEND      = 4'b0100,
    ST_DONE      = 4'b1000
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    logic [31:0] result;
    if (value == 32'hFFFF_FFFF) begin
      result = value;
    end else begin
      result = value + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/acc_result_drain_if.sv
// -----------------------------------------------------------------------------
// acc_result_drain_if
// Valid/ready word stream from the result drain towards the DMA/host path.
//   m_data  : output word
//   m_valid : word valid
//   m_ready : downstream accept
//   m_last  : final word of packet
// Modports: master (drain side), slave (consumer side).
// -----------------------------------------------------------------------------
interface acc_result_drain_if
  import acc_drain_pkg::*;
#(
  parameter int OUT_W = DEF_OUT_W
) ();

  logic [OUT_W-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/acc_drain_shreg.sv
// -----------------------------------------------------------------------------
// acc_drain_shreg
// Beat holding register for the result drain. Captures one FIFO beat plus its
// last flag and presents it one OUT_W word at a time, least-significant first.
//   clk, reset   : clock, synchronous active-low reset
//   load         : capture fifo_data/fifo_last, restart at word 0
//   advance      : step to the next word (ignored on the final word)
//   clear_last   : drop the stored last flag once the packet has closed
//   fifo_data/fifo_last : beat from the FIFO read port
//   word         : currently selected word
//   last_q       : stored last flag of the held beat
//   idx          : current word index
//   at_end       : idx points at the final word of the beat
// -----------------------------------------------------------------------------
module acc_drain_shreg
  import acc_drain_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OUT_W  = DEF_OUT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic                       advance,
  input  logic                       clear_last,
  input  logic [DATA_W-1:0]          fifo_data,
  input  logic                       fifo_last,
  output logic [OUT_W-1:0]           word,
  output logic                       last_q,
  output logic [$clog2(DATA_W/OUT_W)-1:0] idx,
  output logic                       at_end
);

  localparam int RATIO = DATA_W / OUT_W;
  localparam int IDX_W = $clog2(RATIO);

  logic [RATIO-1:0][OUT_W-1:0] beat_r;
  logic                        last_r;
  logic [IDX_W-1:0]            idx_r;

  // Beat storage: overwritten only when a new beat is captured.
  always_ff @(posedge clk) begin
    if (!reset) begin
      beat_r <= '0;
    end else if (load) begin
      beat_r <= fifo_data;
    end
  end

  // Last flag travels with the beat and is dropped after the packet closes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_r <= 1'b0;
    end else if (load) begin
      last_r <= fifo_last;
    end else if (clear_last) begin
      last_r <= 1'b0;
    end
  end

  // Word index: parks on the final word until the next load restarts it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_r <= '0;
    end else if (load) begin
      idx_r <= '0;
    end else if (advance && !at_end) begin
      idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
    end
  end

  assign at_end = (idx_r == IDX_W'(RATIO - 1));
  assign word   = beat_r[idx_r];
  assign last_q = last_r;
  assign idx    = idx_r;

endmodule

// File: rtl/acc_result_drain.sv
// -----------------------------------------------------------------------------
// acc_result_drain
// Reader side of the accelerator output FIFO. Pops DATA_W-bit beats (1-cycle
// read latency), serializes each into DATA_W/OUT_W words on a valid/ready
// stream, and flags packet end with m_last and a one-cycle done pulse.
//   clk, reset  : clock, synchronous active-low reset
//   enable      : allows new FIFO pops (a beat in flight always completes)
//   fifo_empty  : FIFO empty flag
//   fifo_rd_en  : FIFO pop strobe, data returns the following cycle
//   fifo_data   : FIFO read data
//   fifo_last   : last-of-packet flag stored with the data
//   m_if        : output word stream (master modport)
//   busy        : FSM not idle
//   done        : pulse after the final word of a packet is accepted
//   beat_count  : pops in the current/last packet (ACC_DRAIN_BEAT_CNT_EN only)
// Optional feature macro: ACC_DRAIN_BEAT_CNT_EN
// -----------------------------------------------------------------------------
module acc_result_drain
  import acc_drain_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OUT_W  = DEF_OUT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_W-1:0]     fifo_data,
  input  logic                  fifo_last,
  acc_result_drain_if.master    m_if,
  output logic                  busy,
  output logic                  done
`ifdef ACC_DRAIN_BEAT_CNT_EN
  ,
  output logic [31:0]           beat_count
`endif
);

  localparam int RATIO = DATA_W / OUT_W;
  localparam int IDX_W = $clog2(RATIO);

  state_e           state_r;
  state_e           state_s;
  logic             rd_ok_s;
  logic             rd_en_s;
  logic             load_s;
  logic             advance_s;
  logic             clear_last_s;
  logic             valid_s;
  logic [OUT_W-1:0] word_s;
  logic             last_q_s;
  logic [IDX_W-1:0] idx_s;
  logic             at_end_s;

  // A pop is only legal out of reset, when enabled and with data present.
  assign rd_ok_s = reset && enable && !fifo_empty;

  acc_drain_shreg #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W)
  ) u_shreg (
    .clk        (clk),
    .reset      (reset),
    .load       (load_s),
    .advance    (advance_s),
    .clear_last (clear_last_s),
    .fifo_data  (fifo_data),
    .fifo_last  (fifo_last),
    .word       (word_s),
    .last_q     (last_q_s),
    .idx        (idx_s),
    .at_end     (at_end_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_s      = state_r;
    rd_en_s      = 1'b0;
    load_s       = 1'b0;
    advance_s    = 1'b0;
    clear_last_s = 1'b0;
    valid_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rd_ok_s) begin
          rd_en_s = 1'b1;
          state_s = ST_WAIT_DATA;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT_DATA: begin
        // FIFO read data is valid now; capture it at the end of this cycle.
        load_s  = 1'b1;
        state_s = ST_SEND;
      end
      ST_SEND: begin
        valid_s = 1'b1;
        if (m_if.m_ready) begin
          if (!at_end_s) begin
            advance_s = 1'b1;
          end else if (last_q_s) begin
            state_s = ST_DONE;
          end else if (rd_ok_s) begin
            // Chain straight into the next beat: one bubble cycle only.
            rd_en_s = 1'b1;
            state_s = ST_WAIT_DATA;
          end else begin
            // Packet still open; wait in IDLE for more data or enable.
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_DONE: begin
        clear_last_s = 1'b1;
        state_s      = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  assign fifo_rd_en  = rd_en_s;
  assign m_if.m_valid = valid_s;
  assign m_if.m_data  = word_s;
  assign m_if.m_last  = (state_r == ST_SEND) && last_q_s && at_end_s;
  assign busy        = (state_r != ST_IDLE);
  assign done        = (state_r == ST_DONE);

`ifdef ACC_DRAIN_BEAT_CNT_EN
  logic [31:0] beat_cnt_r;
  logic        pkt_closed_r;

  // Pop counter: restarts at 1 on the first pop after a packet has closed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      beat_cnt_r   <= 32'd0;
      pkt_closed_r <= 1'b0;
    end else if (rd_en_s) begin
      beat_cnt_r   <= pkt_closed_r ? 32'd1 : sat_inc32(beat_cnt_r);
      pkt_closed_r <= 1'b0;
    end else if (state_r == ST_DONE) begin
      pkt_closed_r <= 1'b1;
    end
  end

  assign beat_count = beat_cnt_r;
`endif

endmodule

// File: tb/tb_acc_result_drain.sv
// -----------------------------------------------------------------------------
// tb_acc_result_drain
// Directed bench for acc_result_drain. A small FIFO model with 1-cycle read
// latency feeds the DUT; inputs change on the falling edge and outputs are
// checked 1 ns later against cycle-indexed expectations.
// Control vector order in checks: {fifo_rd_en, m_valid, m_last, done, busy}.
// -----------------------------------------------------------------------------
module tb_acc_result_drain;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         fifo_empty;
  logic         fifo_rd_en;
  logic [127:0] fifo_data = '0;
  logic         fifo_last = 1'b0;
  logic         busy;
  logic         done;
`ifdef ACC_DRAIN_BEAT_CNT_EN
  logic [31:0]  beat_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [128:0] fmem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;

  acc_result_drain_if #(.OUT_W(32)) s_if ();

  acc_result_drain #(
    .DATA_W (128),
    .OUT_W  (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .fifo_last  (fifo_last),
    .m_if       (s_if),
    .busy       (busy),
    .done       (done)
`ifdef ACC_DRAIN_BEAT_CNT_EN
    ,
    .beat_count (beat_count)
`endif
  );

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  // FIFO model: pop on rd_en, data appears the following cycle.
  always @(posedge clk) begin
    if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
      {fifo_last, fifo_data} <= fmem[rd_ptr % 16];
      rd_ptr <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [127:0] data, input logic last);
    fmem[wr_ptr % 16] = {last, data};
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 2) reset = 1'b1;
      #1;
      obs = {fifo_rd_en, s_if.m_valid, s_if.m_last, done, busy};
      n_cmp++;
      if (obs !== 5'b00000) begin
        n_err++;
        $display("FAIL reset_ctrl k=%0d got %b exp 00000", k, obs);
      end
      n_cmp++;
      if (s_if.m_data !== 32'h0) begin
        n_err++;
        $display("FAIL reset_data k=%0d got %h exp 00000000", k, s_if.m_data);
      end
`ifdef ACC_DRAIN_BEAT_CNT_EN
      n_cmp++;
      if (beat_count !== 32'd0) begin
        n_err++;
        $display("FAIL reset_beat_count k=%0d got %0d exp 0", k, beat_count);
      end
`endif
    end
  endtask

  task automatic test_single_beat();
    logic [127:0] beat;
    logic [4:0]   obs;
    logic [4:0]   exp;
    logic [31:0]  exp_w;
    beat = 128'h0000000F_0000000E_0000000D_0000000C;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k == 0) begin
        push(beat, 1'b1);
        enable = 1'b1;
      end
      #1;
      exp = {k == 0, (k >= 2) && (k <= 5), k == 5, k == 6, (k >= 1) && (k <= 6)};
      obs = {fifo_rd_en, s_if.m_valid, s_if.m_last, done, busy};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL single_ctrl k=%0d got %b exp %b", k, obs, exp);
      end
      if (exp[3]) begin
        exp_w = beat[(k-2)*32 +: 32];
        n_cmp++;
        if (s_if.m_data !== exp_w) begin
          n_err++;
          $display("FAIL single_data k=%0d got %h exp %h", k, s_if.m_data, exp_w);
        end
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_three_beat();
    logic [127:0] bt [3];
    logic [4:0]   obs;
    logic [4:0]   exp;
    logic [31:0]  exp_w;
    int           b;
    int           i;
    bt[0] = 128'h00001003_00001002_00001001_00001000;
    bt[1] = 128'h00002003_00002002_00002001_00002000;
    bt[2] = 128'h00003003_00003002_00003001_00003000;
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      if (k == 0) begin
        push(bt[0], 1'b0);
        push(bt[1], 1'b0);
        push(bt[2], 1'b1);
        enable = 1'b1;
      end
      #1;
      exp = {(k == 0) || (k == 5) || (k == 10),
             (k >= 2) && (k <= 15) && (((k - 2) % 5) != 4),
             k == 15, k == 16, (k >= 1) && (k <= 16)};
      obs = {fifo_rd_en, s_if.m_valid, s_if.m_last, done, busy};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL three_ctrl k=%0d got %b exp %b", k, obs, exp);
      end
      if (exp[3]) begin
        b = (k - 2) / 5;
        i = (k - 2) % 5;
        exp_w = bt[b][i*32 +: 32];
        n_cmp++;
        if (s_if.m_data !== exp_w) begin
          n_err++;
          $display("FAIL three_data k=%0d got %h exp %h", k, s_if.m_data, exp_w);
        end
      end
    end
    enable = 1'b0;
  endtask

`ifdef ACC_DRAIN_BEAT_CNT_EN
  task automatic test_beat_count();
    logic [127:0] beat;
    beat = 128'h00005003_00005002_00005001_00005000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (beat_count !== 32'd3) begin
        n_err++;
        $display("FAIL beat_count_hold k=%0d got %0d exp 3", k, beat_count);
      end
    end
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k == 0) begin
        push(beat, 1'b1);
        enable = 1'b1;
      end
      #1;
      if (k == 0) begin
        n_cmp++;
        if (beat_count !== 32'd3) begin
          n_err++;
          $display("FAIL beat_count_pre_pop got %0d exp 3", beat_count);
        end
      end else begin
        n_cmp++;
        if (beat_count !== 32'd1) begin
          n_err++;
          $display("FAIL beat_count_restart k=%0d got %0d exp 1", k, beat_count);
        end
      end
    end
    enable = 1'b0;
  endtask
`endif

  task automatic test_backpressure();
    logic [127:0] bt [2];
    logic [4:0]   obs;
    logic [4:0]   exp;
    logic [31:0]  exp_w;
    int           b;
    int           i;
    bt[0] = 128'h00004003_00004002_00004001_00004000;
    bt[1] = 128'h00004103_00004102_00004101_00004100;
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      if (k == 0) begin
        push(bt[0], 1'b0);
        push(bt[1], 1'b1);
        enable = 1'b1;
      end
      s_if.m_ready = !((k >= 3) && (k <= 7));
      #1;
      exp = {(k == 0) || (k == 10),
             ((k >= 2) && (k <= 10)) || ((k >= 12) && (k <= 15)),
             k == 15, k == 16, (k >= 1) && (k <= 16)};
      obs = {fifo_rd_en, s_if.m_valid, s_if.m_last, done, busy};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL stall_ctrl k=%0d got %b exp %b", k, obs, exp);
      end
      if (exp[3]) begin
        if (k == 2) begin
          b = 0; i = 0;
        end else if (k <= 8) begin
          b = 0; i = 1;
        end else if (k <= 10) begin
          b = 0; i = k - 7;
        end else begin
          b = 1; i = k - 12;
        end
        exp_w = bt[b][i*32 +: 32];
        n_cmp++;
        if (s_if.m_data !== exp_w) begin
          n_err++;
          $display("FAIL stall_data k=%0d got %h exp %h", k, s_if.m_data, exp_w);
        end
      end
    end
    s_if.m_ready = 1'b1;
    enable = 1'b0;
  endtask

  task automatic test_fifo_underrun();
    logic [127:0] bt [2];
    logic [4:0]   obs;
    logic [4:0]   exp;
    logic [31:0]  exp_w;
    bt[0] = 128'h00006003_00006002_00006001_00006000;
    bt[1] = 128'h00006103_00006102_00006101_00006100;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (k == 0) begin
        push(bt[0], 1'b0);
        enable = 1'b1;
      end
      if (k == 16) push(bt[1], 1'b1);
      #1;
      exp = {(k == 0) || (k == 16),
             ((k >= 2) && (k <= 5)) || ((k >= 18) && (k <= 21)),
             k == 21, k == 22,
             ((k >= 1) && (k <= 5)) || ((k >= 17) && (k <= 22))};
      obs = {fifo_rd_en, s_if.m_valid, s_if.m_last, done, busy};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL underrun_ctrl k=%0d got %b exp %b", k, obs, exp);
      end
      if (exp[3]) begin
        if (k <= 5) exp_w = bt[0][(k-2)*32 +: 32];
        else        exp_w = bt[1][(k-18)*32 +: 32];
        n_cmp++;
        if (s_if.m_data !== exp_w) begin
          n_err++;
          $display("FAIL underrun_data k=%0d got %h exp %h", k, s_if.m_data, exp_w);
        end
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [127:0] bt [2];
    logic [4:0]   obs;
    logic [4:0]   exp;
    logic [31:0]  exp_w;
    bt[0] = 128'h00007003_00007002_00007001_00007000;
    bt[1] = 128'h00007103_00007102_00007101_00007100;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (k == 0) begin
        push(bt[0], 1'b0);
        push(bt[1], 1'b1);
        enable = 1'b1;
      end
      if (k == 4) reset = 1'b0;
      if (k == 6) reset = 1'b1;
      #1;
      exp = {(k == 0) || (k == 6),
             ((k >= 2) && (k <= 4)) || ((k >= 8) && (k <= 11)),
             k == 11, k == 12,
             ((k >= 1) && (k <= 4)) || ((k >= 7) && (k <= 12))};
      obs = {fifo_rd_en, s_if.m_valid, s_if.m_last, done, busy};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL midrst_ctrl k=%0d got %b exp %b", k, obs, exp);
      end
      if (exp[3] || (k == 5)) begin
        if (k == 5)      exp_w = 32'h0;
        else if (k <= 4) exp_w = bt[0][(k-2)*32 +: 32];
        else             exp_w = bt[1][(k-8)*32 +: 32];
        n_cmp++;
        if (s_if.m_data !== exp_w) begin
          n_err++;
          $display("FAIL midrst_data k=%0d got %h exp %h", k, s_if.m_data, exp_w);
        end
      end
    end
    enable = 1'b0;
  endtask

  initial begin
    reset        = 1'b0;
    enable       = 1'b0;
    s_if.m_ready = 1'b1;
    test_reset();
    test_single_beat();
    test_three_beat();
`ifdef ACC_DRAIN_BEAT_CNT_EN
    test_beat_count();
`endif
    test_backpressure();
    test_fifo_underrun();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/acc_result_drain.md
Name: acc_result_drain

Overview:
- Reader side of the accelerator's output FIFO.
- Pops 128-bit computed beats (with their last sideband flag) from the FIFO and serializes each beat into four 32-bit words.
- Presents the words on a valid/ready master stream towards the DMA/host write path.
- Signals end of packet with m_last and a done pulse.

Parameters:
- DATA_W, 128, FIFO beat width.
- OUT_W, 32, output word width; DATA_W must be an integer multiple of OUT_W.
- RATIO, DATA_W/OUT_W (4), words per beat; derived, not overridable.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  drain permitted; gates new FIFO reads only.
- fifo_empty  in  1  output FIFO empty.
- fifo_rd_en  out  1  FIFO pop strobe; data is valid the cycle after.
- fifo_data  in  DATA_W  FIFO read data (1-cycle read latency).
- fifo_last  in  1  last flag stored alongside the data; same latency as fifo_data.
- m_data  out  OUT_W  output word.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- m_last  out  1  final word of packet.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after the final word is accepted.

Behaviour:
- Reset values: fifo_rd_en=0, m_valid=0, m_last=0, m_data=0, busy=0, done=0, idx=0, state=IDLE.
- States, one-hot: IDLE, WAIT_DATA, SEND, DONE.
- IDLE:
  - fifo_rd_en = enable && !fifo_empty (combinational).
  - If asserted, next state is WAIT_DATA.
- WAIT_DATA:
  - Lasts exactly 1 cycle.
  - At its end, fifo_data is captured into the shift register and fifo_last into last_q; idx=0; next state is SEND.
- SEND:
  - m_valid=1; m_data = shreg[idx*OUT_W +: OUT_W]. Word order is least-significant word first.
  - Handshake = m_valid && m_ready. On handshake with idx<RATIO-1: idx++.
  - On handshake with idx==RATIO-1:
    - If last_q: go to DONE.
    - Else if enable && !fifo_empty: fifo_rd_en=1 in the same cycle (combinational on m_ready), go to WAIT_DATA.
    - Otherwise: go to IDLE.
- m_last = (state==SEND) && last_q && idx==RATIO-1.
- DONE: done=1 for 1 cycle, then IDLE; last_q is cleared.
- Latency: fifo_rd_en in cycle N gives first m_valid in cycle N+2.
- Throughput: sustained 4 words per 5 cycles; one bubble cycle between beats.
- Stability: while m_valid && !m_ready, m_data, m_last and idx hold. m_valid never drops without a handshake.
- fifo_rd_en is never asserted when fifo_empty=1, and at most once per beat.
- enable deasserted mid-beat: the current beat completes, no new pop; resume from IDLE when re-enabled.
- FIFO empties between beats of an open packet: go to IDLE and wait. The packet stays open; m_last occurs only on a beat whose fifo_last=1.
- Reset mid-operation: all state cleared next edge and the partial beat is discarded. fifo_rd_en is not asserted in the reset cycle.
- Simultaneous final handshake and fifo_empty falling: the empty value sampled in that cycle decides; there is no look-ahead.

Optional Feature:
- Macro: ACC_DRAIN_BEAT_CNT_EN.
- When defined:
  - Adds output beat_count [31:0], reset 0.
  - Increments on every fifo_rd_en.
  - Holds its value after done; resets to 1 on the first pop of the next packet.
  - Saturates at 32'hFFFFFFFF.
- When undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package acc_drain_pkg holds:
  - state type and one-hot encodings (IDLE=4'b0001, WAIT_DATA=4'b0010, SEND=4'b0100, DONE=4'b1000);
  - DATA_W/OUT_W defaults;
  - RATIO and the idx width, $clog2(RATIO).
- One sub-module: acc_drain_shreg. It holds the beat register, last_q, the idx counter and word select, with load/advance inputs.
- The FSM and FIFO control stay in the top.

Test Plan:
- Single beat, fifo_data=128'h0000000F_0000000E_0000000D_0000000C, fifo_last=1, m_ready=1:
  - one fifo_rd_en pulse;
  - m_data 0C,0D,0E,0F on 4 consecutive cycles starting 2 cycles after rd_en;
  - m_last only with 0F;
  - done pulse the next cycle.
- 3-beat packet, m_ready=1: 12 words, exactly 3 rd_en pulses, one bubble between beats, m_last only on word 12.
- m_ready low for 5 cycles at idx=1: m_data/m_valid/m_last held; no rd_en issued; sequence resumes unchanged.
- FIFO empty after beat 1 (fifo_last=0): state goes to IDLE, busy=0, no m_last. A beat with fifo_last=1 pushed 10 cycles later yields 4 words with m_last on word 4.
- Reset low during SEND idx=2: next cycle m_valid=0, fifo_rd_en=0. After release, the next beat starts at word 0.
- With ACC_DRAIN_BEAT_CNT_EN: beat_count=3 after the 3-beat packet and holds. The first pop of the next packet sets it to 1.
